gpio_in_conditioner: RTL
========================

// Module: gpio_in_conditioner
//
// PURPOSE
// Conditions raw asynchronous GPIO pins before they reach the CPU's i_gpio_in
// input, which the CPU reads as already-synchronous data. Each bit passes
// through a SYNC_STAGES-flop synchronizer and then an independent debounce
// filter. One-cycle rise/fall pulses are produced for each bit alongside the
// filtered level. The block sits between the top-level pins and cpu.i_gpio_in.
//
// PARAMETERS
// WIDTH            32  number of GPIO input bits
// SYNC_STAGES      2   synchronizer depth; must be >= 2
// DEBOUNCE_CYCLES  16  consecutive disagreeing cycles needed to accept a change; must be >= 1
// RESET_VALUE      0   WIDTH-bit value loaded into the synchronizer and o_gpio_in on reset
//
// PORTS
// i_clk            in   1      clock
// i_rst            in   1      synchronous reset, active-high
// i_pins           in   WIDTH  raw asynchronous pin levels
// i_bypass_mask    in   WIDTH  1 = bit skips the debounce filter (synchronizer only); synchronous input
// o_gpio_in        out  WIDTH  filtered level; drives cpu.i_gpio_in
// o_rise           out  WIDTH  1-cycle pulse when o_gpio_in[i] goes 0->1
// o_fall           out  WIDTH  1-cycle pulse when o_gpio_in[i] goes 1->0
//
// BEHAVIOUR
// Reset (i_rst high at a posedge):
//   - All synchronizer flops and o_gpio_in load RESET_VALUE.
//   - All counters load 0; o_rise and o_fall load 0.
//   - Reset wins over every other event; an in-progress debounce is discarded.
// Synchronizer:
//   - sync[i] is the last flop of the chain; it reflects i_pins[i] SYNC_STAGES edges later.
// Per-bit counter:
//   - cnt[i] is $clog2(DEBOUNCE_CYCLES+1) bits wide, unsigned.
//   - A DEBOUNCE_CYCLES-long run never overflows it.
// Debounce path (i_bypass_mask[i]=0), each posedge:
//   - sync[i]==o_gpio_in[i]: cnt<=0, output held.
//   - sync[i]!=o_gpio_in[i] and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
//   - sync[i]!=o_gpio_in[i] and cnt==DEBOUNCE_CYCLES-1: o_gpio_in[i]<=sync[i], cnt<=0.
// Latency and glitches:
//   - A clean pin step shows on o_gpio_in at edge SYNC_STAGES+DEBOUNCE_CYCLES after the
//     first edge sampling the new level.
//   - A glitch lasting fewer than DEBOUNCE_CYCLES synchronized cycles never reaches the output.
//     Any agreeing cycle restarts the count.
//   - DEBOUNCE_CYCLES=1: output follows sync[i] one edge later.
// Bypass path (i_bypass_mask[i]=1):
//   - Each posedge: o_gpio_in[i]<=sync[i], cnt[i]<=0; latency SYNC_STAGES+1.
//   - Mask change 1->0 mid-activity: the count starts from 0, and the output holds its last value.
//   - Mask change 0->1: any partial count is dropped and the output tracks sync on the next edge.
// Edge pulses:
//   - o_rise and o_fall are registered at the same edge as the o_gpio_in[i] update.
//   - Each is high for exactly one cycle, and never both in the same cycle for the same bit.
//   - No pulse is generated by reset.
// Bits are fully independent; changes on different bits in the same cycle are each handled normally.
// All outputs are registered; there is no combinational path from inputs to outputs.
//
// TESTING
// (1) Reset with RESET_VALUE=32'h0000_00A5 and i_pins=0 for 1 cycle
//     -> o_gpio_in=32'hA5 and o_rise=o_fall=0 the cycle after reset.
// (2) i_pins[0] steps 0->1 and holds; SYNC_STAGES=2, DEBOUNCE_CYCLES=16
//     -> o_gpio_in[0]=1 exactly 18 edges after the first sampling edge.
//     -> o_rise[0] high for that single cycle only.
// (3) i_pins[3] pulses high for 15 cycles, then low
//     -> o_gpio_in[3] stays 0 and no rise/fall pulse occurs.
//     -> A repeat with a 16-cycle pulse toggles o_gpio_in[3] high then low, with one rise and one fall.
// (4) i_bypass_mask=32'h1; i_pins[0] toggles each 4 cycles
//     -> o_gpio_in[0] follows with 3-edge latency, and o_rise/o_fall alternate.
// (5) i_pins[7] goes high; i_rst is asserted 10 cycles into the debounce
//     -> o_gpio_in[7] = RESET_VALUE[7], and the count restarts.
//     -> After reset release, the output changes a full 18 edges later.
// (6) i_pins=32'hFFFF_FFFF from all-zero in one cycle
//     -> all 32 bits update on the same edge, and o_rise=32'hFFFF_FFFF for one cycle.

Source files
------------

// File: rtl/gpio_in_conditioner.sv
// Per-bit synchronizer + debounce filter for raw GPIO pins, with 1-cycle rise/fall pulses.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges (SYNC_STAGES+1 when bypassed); no backpressure, all outputs registered.
module gpio_in_conditioner #(
  parameter int                WIDTH           = 32,
  parameter int                SYNC_STAGES     = 2,
  parameter int                DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0]  RESET_VALUE     = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_pins,
  input  logic [WIDTH-1:0] i_bypass_mask,
  output logic [WIDTH-1:0] o_gpio_in,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] level_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_VALUE;
    end else begin
      sync_q[0] <= i_pins;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Any agreeing cycle (or bypass) clears the run; the last disagreeing cycle commits the new level.
  always_comb begin
    level_d = o_gpio_in;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (i_bypass_mask[i]) begin
        level_d[i] = sync[i];
      end else if (sync[i] != o_gpio_in[i]) begin
        if (cnt_q[i] == CNT_LAST) level_d[i] = sync[i];
        else                      cnt_d[i]   = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_gpio_in <= RESET_VALUE;
      o_rise    <= '0;
      o_fall    <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      o_gpio_in <= level_d;
      o_rise    <= level_d & ~o_gpio_in;
      o_fall    <= ~level_d & o_gpio_in;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
